// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage sitting after execute.
//
// Captures one execute entry per transfer. For loads it also captures the
// DCache read data, then aligns and extends it (lb/lbu/lh/lhu/lw/lwl/lwr).
// It publishes forwarding and hazard status and hands the entry to
// writeback using the pipeline-wide valid/allowin handshake.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   ws_allowin         writeback can accept an entry
//   ms_allowin         this stage can accept an entry
//   es_to_ms_valid     execute entry valid
//   es_to_ms_bus       execute-to-memory bus (ES_TO_MS_BUS_WD bits)
//   data_data_ok       DCache read data valid
//   data_rdata         DCache read data
//   flush              exception/eret flush, kills the entry in this stage
//   ms_to_ws_valid     entry to writeback valid
//   ms_to_ws_bus       memory-to-writeback bus (MS_TO_WS_BUS_WD bits)
//   MEM_dest           forwarding destination, 0 when nothing writes back
//   MEM_result         forwarding value
//   ms_load_op         valid load in stage
//   ms_inst_mfc0       valid mfc0 in stage
//   ms_ex              valid excepting instruction in stage
//   ms_inst_eret       valid eret in stage
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 165,
  parameter int MS_TO_WS_BUS_WD = 120
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_data_ok,
  input  logic [31:0]                data_rdata,
  input  logic                       flush,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [4:0]                 MEM_dest,
  output logic [31:0]                MEM_result,
  output logic                       ms_load_op,
  output logic                       ms_inst_mfc0,
  output logic                       ms_ex,
  output logic                       ms_inst_eret
);

  // Sign- or zero-extend a byte.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{24{sgn & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{16{sgn & h[15]}}, h};
  endfunction

  // Align load data. mi is the one-hot mem_inst field:
  // 0 lw, 1 sw, 2 lb, 3 lbu, 4 lh, 5 lhu, 6 lwl, 7 lwr, 8 sb, 9 sh, 10 swl, 11 swr.
  // Stores fall through to the raw word; their result comes from the ALU anyway.
  function automatic logic [31:0] align_load(input logic [11:0] mi,
                                             input logic [1:0]  a,
                                             input logic [31:0] rd,
                                             input logic [31:0] rt);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = rd[8*a +: 8];
    half_sel = a[1] ? rd[31:16] : rd[15:0];
    if (mi[2] || mi[3]) begin
      align_load = ext_byte(byte_sel, mi[2]);
    end else if (mi[4] || mi[5]) begin
      align_load = ext_half(half_sel, mi[4]);
    end else if (mi[6]) begin
      case (a)
        2'd0:    align_load = {rd[7:0],  rt[23:0]};
        2'd1:    align_load = {rd[15:0], rt[15:0]};
        2'd2:    align_load = {rd[23:0], rt[7:0]};
        default: align_load = rd;
      endcase
    end else if (mi[7]) begin
      case (a)
        2'd0:    align_load = rd;
        2'd1:    align_load = {rt[31:24], rd[31:8]};
        2'd2:    align_load = {rt[31:16], rd[31:16]};
        default: align_load = {rt[31:8],  rd[31:24]};
      endcase
    end else begin
      // lw, and any non-load encoding
      align_load = rd | {20'd0, mi[11:8], mi[1], 7'd0} & 32'd0;
    end
  endfunction

  logic                       ms_valid_q,  ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q,       bus_d;
  logic [31:0]                rdata_r_q,   rdata_r_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;
  logic                       pending_q,   pending_d;
  logic                       transfer;

  // Decoded fields of the captured entry.
  logic [31:0] f_addr;
  logic [4:0]  f_mfc0_rd;
  logic        f_ex;
  logic [4:0]  f_exccode;
  logic        f_bd;
  logic        f_eret;
  logic [2:0]  f_sel;
  logic        f_mtc0;
  logic        f_mfc0;
  logic [31:0] f_rt;
  logic [11:0] f_mem_inst;
  logic        f_res_from_mem;
  logic        f_gr_we;
  logic [4:0]  f_dest;
  logic [31:0] f_alu;
  logic [31:0] f_pc;
  logic [31:0] final_result;

  assign ms_allowin = !ms_valid_q || ws_allowin;
  assign transfer   = es_to_ms_valid && ms_allowin;

  // ---- next-state: handshake, entry capture, load data capture ----
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    rdata_r_d   = rdata_r_q;
    rdata_buf_d = rdata_buf_q;
    pending_d   = pending_q;

    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    if (transfer && !flush) begin
      bus_d = es_to_ms_bus;
      // Data may have returned before the entry could move in; prefer it.
      if (es_to_ms_bus[70]) rdata_r_d = pending_q ? rdata_buf_q : data_rdata;
    end

    // Hold read data that arrives while the entry is still stalled upstream.
    if (flush || transfer) begin
      pending_d = 1'b0;
    end else if (data_data_ok && !pending_q) begin
      rdata_buf_d = data_rdata;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      rdata_r_q   <= '0;
      rdata_buf_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      rdata_r_q   <= rdata_r_d;
      rdata_buf_q <= rdata_buf_d;
      pending_q   <= pending_d;
    end
  end

  // ---- outputs: field decode, alignment, forwarding, status ----
  always_comb begin
    f_addr         = bus_q[164:133];
    f_mfc0_rd      = bus_q[132:128];
    f_ex           = bus_q[127];
    f_exccode      = bus_q[126:122];
    f_bd           = bus_q[121];
    f_eret         = bus_q[120];
    f_sel          = bus_q[119:117];
    f_mtc0         = bus_q[116];
    f_mfc0         = bus_q[115];
    f_rt           = bus_q[114:83];
    f_mem_inst     = bus_q[82:71];
    f_res_from_mem = bus_q[70];
    f_gr_we        = bus_q[69];
    f_dest         = bus_q[68:64];
    f_alu          = bus_q[63:32];
    f_pc           = bus_q[31:0];

    final_result = f_res_from_mem
                 ? align_load(f_mem_inst, f_addr[1:0], rdata_r_q, f_rt)
                 : f_alu;

    ms_to_ws_valid = ms_valid_q;
    ms_to_ws_bus   = {f_mfc0_rd, f_ex, f_exccode, f_bd, f_eret, f_sel, f_mtc0,
                      f_mfc0, f_addr, f_gr_we & !f_ex & ms_valid_q, f_dest,
                      final_result, f_pc};

    MEM_dest     = f_dest & {5{ms_valid_q && f_gr_we}};
    MEM_result   = final_result;
    ms_load_op   = ms_valid_q && f_res_from_mem;
    ms_inst_mfc0 = ms_valid_q && f_mfc0;
    ms_ex        = ms_valid_q && f_ex;
    ms_inst_eret = ms_valid_q && f_eret;
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [164:0] es_to_ms_bus;
  logic         data_data_ok;
  logic [31:0]  data_rdata;
  logic         flush;
  logic         ms_to_ws_valid;
  logic [119:0] ms_to_ws_bus;
  logic [4:0]   MEM_dest;
  logic [31:0]  MEM_result;
  logic         ms_load_op;
  logic         ms_inst_mfc0;
  logic         ms_ex;
  logic         ms_inst_eret;

  int total = 0;
  int bad   = 0;

  mem_stage #(.ES_TO_MS_BUS_WD(165), .MS_TO_WS_BUS_WD(120)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .flush          (flush),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .MEM_dest       (MEM_dest),
    .MEM_result     (MEM_result),
    .ms_load_op     (ms_load_op),
    .ms_inst_mfc0   (ms_inst_mfc0),
    .ms_ex          (ms_ex),
    .ms_inst_eret   (ms_inst_eret)
  );

  always #5 clk = ~clk;

  // mem_inst one-hot encodings
  localparam logic [11:0] MI_NONE = 12'h000;
  localparam logic [11:0] MI_LW   = 12'h001;
  localparam logic [11:0] MI_LB   = 12'h004;
  localparam logic [11:0] MI_LBU  = 12'h008;
  localparam logic [11:0] MI_LH   = 12'h010;
  localparam logic [11:0] MI_LWL  = 12'h040;
  localparam logic [11:0] MI_LWR  = 12'h080;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [164:0] mk(input logic [31:0] addr, input logic ex,
                                      input logic [4:0] ecode, input logic eret,
                                      input logic mfc0, input logic [4:0] mrd,
                                      input logic [31:0] rt, input logic [11:0] mi,
                                      input logic rfm, input logic we,
                                      input logic [4:0] dest, input logic [31:0] alu,
                                      input logic [31:0] pc);
    mk = {addr, mrd, ex, ecode, 1'b0, eret, 3'b000, 1'b0, mfc0, rt, mi, rfm, we,
          dest, alu, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one load entry with data returned in the same cycle.
  task automatic do_load(input logic [31:0] addr, input logic [11:0] mi,
                         input logic [31:0] rd, input logic [31:0] rt,
                         input logic [31:0] exp, input string tag);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(addr, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, rt, mi, 1'b1, 1'b1,
                        5'd5, 32'h0, 32'hBFC0_0000);
    data_data_ok   = 1'b1;
    data_rdata     = rd;
    step();
    es_to_ms_valid = 1'b0;
    data_data_ok   = 1'b0;
    chk({tag, "_result"}, ms_to_ws_bus[63:32], exp);
    chk({tag, "_fwd"},    MEM_result, exp);
  endtask

  initial begin
    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_data_ok = 1'b0; data_rdata = '0; flush = 1'b0;
    #12;
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid",   ms_to_ws_valid, 0);
    chk("rst_bus",     ms_to_ws_bus, 0);
    chk("rst_dest",    MEM_dest, 0);
    chk("rst_load",    ms_load_op, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Byte / half / word / unaligned loads
    do_load(32'h0000_1003, MI_LB,  32'h8011_2233, 32'h0, 32'hFFFF_FF80, "lb");
    chk("lb_valid", ms_to_ws_valid, 1);
    chk("lb_loadop", ms_load_op, 1);
    chk("lb_dest", MEM_dest, 5);
    do_load(32'h0000_1003, MI_LBU, 32'h8011_2233, 32'h0, 32'h0000_0080, "lbu");
    do_load(32'h0000_1002, MI_LH,  32'h8011_2233, 32'h0, 32'hFFFF_8011, "lh");
    do_load(32'h0000_1000, MI_LW,  32'h8011_2233, 32'h0, 32'h8011_2233, "lw");
    do_load(32'h0000_1001, MI_LWL, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344, "lwl");
    do_load(32'h0000_1002, MI_LWR, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_AABB, "lwr");
    step();
    chk("drain_valid", ms_to_ws_valid, 0);
    chk("drain_dest",  MEM_dest, 0);

    // Early data buffered while MEM is occupied and stalled
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, MI_NONE, 1'b0,
                        1'b1, 5'd4, 32'h0000_0044, 32'h100);
    step();
    es_to_ms_valid = 1'b0;
    data_data_ok   = 1'b1;
    data_rdata     = 32'h1234_5678;
    chk("buf_allowin", ms_allowin, 0);
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    step();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h0000_2000, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, MI_LW,
                        1'b1, 1'b1, 5'd6, 32'h0, 32'h104);
    step();
    es_to_ms_valid = 1'b0;
    chk("buf_result", MEM_result, 32'h1234_5678);
    // A stale pending buffer would override the fresh data here.
    do_load(32'h0000_2000, MI_LW, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, "post_buf");

    // Writeback stall with an add in MEM
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, MI_NONE, 1'b0,
                        1'b1, 5'd7, 32'hDEAD_0001, 32'h200);
    step();
    ws_allowin   = 1'b0;
    es_to_ms_bus = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, MI_NONE, 1'b0,
                      1'b1, 5'd9, 32'h2222_2222, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_allowin", ms_allowin, 0);
      chk("stall_dest",    MEM_dest, 7);
      chk("stall_result",  MEM_result, 32'hDEAD_0001);
      step();
    end
    ws_allowin = 1'b1;
    #1;
    chk("release_allowin", ms_allowin, 1);
    step();
    es_to_ms_valid = 1'b0;
    chk("handoff_dest",   MEM_dest, 9);
    chk("handoff_result", MEM_result, 32'h2222_2222);
    step();
    chk("handoff_once", ms_to_ws_valid, 0);

    // mfc0 status
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'h0, MI_NONE, 1'b0,
                        1'b1, 5'd2, 32'h0, 32'h300);
    step();
    es_to_ms_valid = 1'b0;
    chk("mfc0_flag", ms_inst_mfc0, 1);
    chk("mfc0_rd",   ms_to_ws_bus[119:115], 12);

    // Excepting entry, then flush colliding with a new transfer
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(32'hBFC0_0123, 1'b1, 5'h04, 1'b1, 1'b0, 5'd0, 32'h0, MI_LW,
                        1'b1, 1'b1, 5'd3, 32'h0, 32'h400);
    data_data_ok   = 1'b1;
    data_rdata     = 32'h0;
    step();
    data_data_ok   = 1'b0;
    chk("ex_grwe",     ms_to_ws_bus[69], 0);
    chk("ex_flag",     ms_ex, 1);
    chk("ex_code",     ms_to_ws_bus[113:109], 5'h04);
    chk("ex_badvaddr", ms_to_ws_bus[101:70], 32'hBFC0_0123);
    chk("ex_eret",     ms_inst_eret, 1);
    flush        = 1'b1;
    es_to_ms_bus = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, MI_NONE, 1'b0,
                      1'b1, 5'd8, 32'h0, 32'h404);
    step();
    flush          = 1'b0;
    es_to_ms_valid = 1'b0;
    chk("flush_valid", ms_to_ws_valid, 0);
    chk("flush_dest",  MEM_dest, 0);
    chk("flush_ex",    ms_ex, 0);

    // Asynchronous reset mid-cycle with a stalled load in stage
    ws_allowin = 1'b0;
    do_load(32'h0000_3000, MI_LW, 32'h5555_AAAA, 32'h0, 32'h5555_AAAA, "pre_rst");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid",   ms_to_ws_valid, 0);
    chk("arst_load",    ms_load_op, 0);
    chk("arst_bus",     ms_to_ws_bus, 0);
    chk("arst_result",  MEM_result, 0);
    chk("arst_allowin", ms_allowin, 1);
    @(negedge clk);
    resetn = 1'b1;
    ws_allowin = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
